// File: rtl/swin_line_ctrl_if.sv
// Pixel-stream / decoder-side bundle for swin_line_ctrl.
//   master : upstream producer + downstream consumer view (drives start,
//            s_pix_data/s_pix_vld, dec_stall; observes everything else)
//   slave  : the scheduler itself
// Signals:
//   start        frame start pulse            busy         scheduler active
//   s_pix_data   128-bit upstream beat        s_pix_vld    upstream valid
//   s_pix_rdy    upstream ready               dec_stall    decoder back-pressure
//   pix_data_out registered beat              data_in_vld  pix_data_out valid
//   decoder_en   decoder / config-BRAM enable line_start   first beat of line
//   line_end     last beat of line            frame_end    final-beat marker
//   row_sel      BRAM row group               win_vld      window rows filled
//   line_cnt     current line index           beat_cnt     next beat index
interface swin_line_ctrl_if #(
    parameter int CNT_W = 12
);
    logic             start;
    logic             busy;
    logic [127:0]     s_pix_data;
    logic             s_pix_vld;
    logic             s_pix_rdy;
    logic             dec_stall;
    logic [127:0]     pix_data_out;
    logic             data_in_vld;
    logic             decoder_en;
    logic             line_start;
    logic             line_end;
    logic             frame_end;
    logic [1:0]       row_sel;
    logic             win_vld;
    logic [CNT_W-1:0] line_cnt;
    logic [CNT_W-1:0] beat_cnt;

    modport slave (
        input  start, s_pix_data, s_pix_vld, dec_stall,
        output busy, s_pix_rdy, pix_data_out, data_in_vld, decoder_en,
               line_start, line_end, frame_end, row_sel, win_vld,
               line_cnt, beat_cnt
    );

    modport master (
        output start, s_pix_data, s_pix_vld, dec_stall,
        input  busy, s_pix_rdy, pix_data_out, data_in_vld, decoder_en,
               line_start, line_end, frame_end, row_sel, win_vld,
               line_cnt, beat_cnt
    );
endinterface

// File: rtl/swin_line_ctrl.sv
// Line/frame scheduler in front of the configuration decoder.
// Accepts 16-pixel beats (valid/ready), forwards them one cycle later with
// data_in_vld, primes the config-BRAM read pipeline before each frame,
// counts beats/lines, inserts an inter-line gap and produces the line/frame
// markers, rotating row-group select and window-valid flag.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset
//   bus  - swin_line_ctrl_if.slave bundle (see interface header)
module swin_line_ctrl #(
    parameter int LINE_BEATS  = 120,
    parameter int FRAME_LINES = 1080,
    parameter int WIN_ROWS    = 3,
    parameter int PRIME_CYC   = 2,   // 0..256
    parameter int GAP_CYC     = 2,   // 0..256
    parameter int CNT_W       = 12
) (
    input  logic               clk,
    input  logic               rst,
    swin_line_ctrl_if.slave    bus
);
    typedef enum logic [2:0] {IDLE, PRIME, RUN, GAP, DONE} state_t;

    localparam logic [CNT_W-1:0] LAST_BEAT  = CNT_W'(LINE_BEATS - 1);
    localparam logic [CNT_W-1:0] LAST_LINE  = CNT_W'(FRAME_LINES - 1);
    localparam logic [CNT_W-1:0] WIN_LINE   = CNT_W'(WIN_ROWS - 1);
    localparam logic [1:0]       LAST_ROW   = 2'(WIN_ROWS - 1);
    // Only compared while in PRIME/GAP, which are skipped when the count is 0.
    localparam logic [7:0]       PRIME_LAST = 8'(PRIME_CYC - 1);
    localparam logic [7:0]       GAP_LAST   = 8'(GAP_CYC - 1);

    state_t             state_reg, state_next;
    logic [7:0]         cyc_reg, cyc_next;
    logic [CNT_W-1:0]   beat_cnt_reg, line_cnt_reg;
    logic [1:0]         row_sel_reg;
    logic [127:0]       pix_data_reg;
    logic               data_in_vld_reg, line_start_reg, line_end_reg, win_vld_reg;

    logic rdy, xfer, last_beat, last_line, frame_go;

    assign rdy       = (state_reg == RUN) & ~bus.dec_stall;
    assign xfer      = bus.s_pix_vld & rdy;
    assign last_beat = (beat_cnt_reg == LAST_BEAT);
    assign last_line = (line_cnt_reg == LAST_LINE);
    assign frame_go  = (state_reg == IDLE) & bus.start;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            cyc_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cyc_reg   <= cyc_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cyc_next   = cyc_reg;
        case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    cyc_next   = '0;
                    state_next = (PRIME_CYC == 0) ? RUN : PRIME;
                end
            end
            PRIME: begin
                if (cyc_reg == PRIME_LAST) state_next = RUN;
                else                       cyc_next   = cyc_reg + 8'd1;
            end
            RUN: begin
                if (xfer && last_beat) begin
                    cyc_next = '0;
                    if (last_line)         state_next = DONE;
                    else if (GAP_CYC == 0) state_next = RUN;
                    else                   state_next = GAP;
                end
            end
            GAP: begin
                if (cyc_reg == GAP_LAST) state_next = RUN;
                else                     cyc_next   = cyc_reg + 8'd1;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Beat path and counters. Markers are registered with the beat so they
    // line up with data_in_vld; pix_data_out holds between transfers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pix_data_reg    <= '0;
            data_in_vld_reg <= 1'b0;
            line_start_reg  <= 1'b0;
            line_end_reg    <= 1'b0;
            win_vld_reg     <= 1'b0;
            beat_cnt_reg    <= '0;
            line_cnt_reg    <= '0;
            row_sel_reg     <= '0;
        end else begin
            data_in_vld_reg <= xfer;
            line_start_reg  <= xfer & (beat_cnt_reg == '0);
            line_end_reg    <= xfer & last_beat;
            if (xfer) begin
                pix_data_reg <= bus.s_pix_data;
                win_vld_reg  <= (line_cnt_reg >= WIN_LINE);
            end
            if (frame_go) begin
                beat_cnt_reg <= '0;
                line_cnt_reg <= '0;
                row_sel_reg  <= '0;
                win_vld_reg  <= 1'b0;
            end else if (xfer) begin
                if (last_beat) begin
                    beat_cnt_reg <= '0;
                    if (!last_line) begin
                        line_cnt_reg <= line_cnt_reg + 1'b1;
                        row_sel_reg  <= (row_sel_reg == LAST_ROW) ? 2'd0 : row_sel_reg + 2'd1;
                    end
                end else begin
                    beat_cnt_reg <= beat_cnt_reg + 1'b1;
                end
            end
        end
    end

    assign bus.busy         = (state_reg != IDLE);
    assign bus.decoder_en   = (state_reg == PRIME) | (state_reg == RUN) | (state_reg == GAP);
    assign bus.frame_end    = (state_reg == DONE);  // DONE is the cycle the final beat is presented
    assign bus.s_pix_rdy    = rdy;
    assign bus.pix_data_out = pix_data_reg;
    assign bus.data_in_vld  = data_in_vld_reg;
    assign bus.line_start   = line_start_reg;
    assign bus.line_end     = line_end_reg;
    assign bus.win_vld      = win_vld_reg;
    assign bus.row_sel      = row_sel_reg;
    assign bus.line_cnt     = line_cnt_reg;
    assign bus.beat_cnt     = beat_cnt_reg;
endmodule

// File: tb/tb_swin_line_ctrl.sv
// Directed bench for swin_line_ctrl.
// dut_a: 4 beats x 2 lines, 2-cycle gap  (timing table, stall, start-in-RUN, reset)
// dut_c: 4 beats x 5 lines, no gap       (row rotation, window flag, upstream bubbles)
module tb_swin_line_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    swin_line_ctrl_if #(.CNT_W(12)) ia ();
    swin_line_ctrl_if #(.CNT_W(12)) ic ();

    swin_line_ctrl #(.LINE_BEATS(4), .FRAME_LINES(2), .WIN_ROWS(3),
                     .PRIME_CYC(2), .GAP_CYC(2), .CNT_W(12))
        dut_a (.clk(clk), .rst(rst), .bus(ia.slave));

    swin_line_ctrl #(.LINE_BEATS(4), .FRAME_LINES(5), .WIN_ROWS(3),
                     .PRIME_CYC(2), .GAP_CYC(0), .CNT_W(12))
        dut_c (.clk(clk), .rst(rst), .bus(ic.slave));

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic logic [127:0] pat(input int i);
        return {4{32'(i) ^ 32'hA5A5_0000}};
    endfunction

    // beat / frame_end monitor for dut_a (tests take differences)
    int beats_a = 0;
    int fe_a    = 0;
    always @(negedge clk) begin
        if (ia.data_in_vld) beats_a++;
        if (ia.frame_end)   fe_a++;
    end

    typedef struct {
        logic start, vld;
        logic busy, den, rdy, dvld, ls, le, fe;
        int   src;   // row whose s_pix_data must appear on pix_data_out, -1 = none
    } vec_t;
    vec_t tv[15];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int b0, f0, rcv, sent, fe_c, bubbles;
        logic found, tog, seen_rdy, xfer;

        ia.start = 0; ia.s_pix_vld = 0; ia.s_pix_data = '0; ia.dec_stall = 0;
        ic.start = 0; ic.s_pix_vld = 0; ic.s_pix_data = '0; ic.dec_stall = 0;

        // ---------------- reset state
        #2;
        chk("rst busy", ia.busy, 0);
        chk("rst den", ia.decoder_en, 0);
        chk("rst dvld", ia.data_in_vld, 0);
        chk("rst fe", ia.frame_end, 0);
        chk("rst pix", ia.pix_data_out, 0);
        chk("rst counters", {ia.row_sel, ia.line_cnt, ia.beat_cnt, ia.win_vld}, 0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 0;
        @(posedge clk); #1;

        // ---------------- test 1: frame timing table
        //              st v  busy den rdy dvld ls le fe src
        tv[0]  = '{1, 1, 0, 0, 0, 0, 0, 0, 0, -1};
        tv[1]  = '{0, 1, 1, 1, 0, 0, 0, 0, 0, -1};
        tv[2]  = '{0, 1, 1, 1, 0, 0, 0, 0, 0, -1};
        tv[3]  = '{0, 1, 1, 1, 1, 0, 0, 0, 0, -1};
        tv[4]  = '{0, 1, 1, 1, 1, 1, 1, 0, 0,  3};
        tv[5]  = '{0, 1, 1, 1, 1, 1, 0, 0, 0,  4};
        tv[6]  = '{0, 1, 1, 1, 1, 1, 0, 0, 0,  5};
        tv[7]  = '{0, 1, 1, 1, 0, 1, 0, 1, 0,  6};
        tv[8]  = '{0, 1, 1, 1, 0, 0, 0, 0, 0, -1};
        tv[9]  = '{0, 1, 1, 1, 1, 0, 0, 0, 0, -1};
        tv[10] = '{0, 1, 1, 1, 1, 1, 1, 0, 0,  9};
        tv[11] = '{0, 1, 1, 1, 1, 1, 0, 0, 0, 10};
        tv[12] = '{0, 1, 1, 1, 1, 1, 0, 0, 0, 11};
        tv[13] = '{0, 1, 1, 0, 0, 1, 0, 1, 1, 12};
        tv[14] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, -1};
        for (int i = 0; i < 15; i++) begin
            ia.start = tv[i].start; ia.s_pix_vld = tv[i].vld; ia.s_pix_data = pat(i);
            @(negedge clk);
            chk($sformatf("t1[%0d] busy", i), ia.busy, tv[i].busy);
            chk($sformatf("t1[%0d] den", i), ia.decoder_en, tv[i].den);
            chk($sformatf("t1[%0d] rdy", i), ia.s_pix_rdy, tv[i].rdy);
            chk($sformatf("t1[%0d] dvld/ls/le/fe", i),
                {ia.data_in_vld, ia.line_start, ia.line_end, ia.frame_end},
                {tv[i].dvld, tv[i].ls, tv[i].le, tv[i].fe});
            if (tv[i].src >= 0)
                chk($sformatf("t1[%0d] data", i), ia.pix_data_out, pat(tv[i].src));
            @(posedge clk); #1;
        end

        // ---------------- tests 2+4: stall at beat 2, start pulsed during RUN
        b0 = beats_a; f0 = fe_a;
        ia.s_pix_vld = 1; ia.s_pix_data = pat(50); ia.start = 1;
        @(posedge clk); #1 ia.start = 0;
        found = 0;
        for (int n = 0; n < 40 && !found; n++) begin
            @(negedge clk);
            if (ia.s_pix_rdy && ia.line_cnt == 0 && ia.beat_cnt == 2) found = 1;
        end
        chk("t2 reach beat2", found, 1);
        ia.dec_stall = 1;
        #1 chk("t2 rdy during stall", ia.s_pix_rdy, 0);
        for (int n = 0; n < 5; n++) begin
            if (n == 1) ia.start = 1;
            if (n == 3) ia.start = 0;
            @(posedge clk); @(negedge clk);
            chk($sformatf("t2 stall%0d dvld", n), ia.data_in_vld, 0);
            chk($sformatf("t2 stall%0d beat_cnt", n), ia.beat_cnt, 2);
        end
        ia.dec_stall = 0; ia.start = 0; ia.s_pix_data = 128'hBEEF_0002;
        @(posedge clk); @(negedge clk);
        chk("t2 resume dvld", ia.data_in_vld, 1);
        chk("t2 resume data", ia.pix_data_out, 128'hBEEF_0002);
        chk("t2 resume ls/le", {ia.line_start, ia.line_end}, 2'b00);
        ia.s_pix_data = pat(60);
        found = 0;
        for (int n = 0; n < 60 && !found; n++) begin
            @(negedge clk);
            if (!ia.busy) found = 1;
        end
        chk("t4 frame finished", found, 1);
        chk("t4 beats", beats_a - b0, 8);
        chk("t4 frame_end count", fe_a - f0, 1);

        // ---------------- test 5: reset at line 1, beat 2
        @(posedge clk); #1;
        f0 = fe_a;
        ia.start = 1;
        @(posedge clk); #1 ia.start = 0;
        found = 0;
        for (int n = 0; n < 40 && !found; n++) begin
            @(negedge clk);
            if (ia.s_pix_rdy && ia.line_cnt == 1 && ia.beat_cnt == 2) found = 1;
        end
        chk("t5 reach l1b2", found, 1);
        #2 rst = 1;
        #1;
        chk("t5 async busy/den/rdy", {ia.busy, ia.decoder_en, ia.s_pix_rdy}, 0);
        chk("t5 async markers", {ia.data_in_vld, ia.line_start, ia.line_end, ia.frame_end, ia.win_vld}, 0);
        chk("t5 async counters", {ia.row_sel, ia.line_cnt, ia.beat_cnt}, 0);
        chk("t5 async pix", ia.pix_data_out, 0);
        @(posedge clk); @(negedge clk);
        rst = 0;
        chk("t5 no frame_end", fe_a - f0, 0);
        @(posedge clk); #1;
        b0 = beats_a; f0 = fe_a;
        ia.start = 1; ia.s_pix_data = pat(70);
        @(posedge clk); #1 ia.start = 0;
        found = 0;
        for (int n = 0; n < 20 && !found; n++) begin
            @(negedge clk);
            if (ia.data_in_vld) found = 1;
        end
        chk("t5 first beat seen", found, 1);
        chk("t5 first beat line_start", ia.line_start, 1);
        chk("t5 first beat data", ia.pix_data_out, pat(70));
        found = 0;
        for (int n = 0; n < 60 && !found; n++) begin
            @(negedge clk);
            if (!ia.busy) found = 1;
        end
        chk("t5 frame finished", found, 1);
        chk("t5 beats", beats_a - b0, 8);
        chk("t5 frame_end count", fe_a - f0, 1);
        ia.s_pix_vld = 0;

        // ---------------- tests 3+6: dut_c, toggling upstream valid, no gap
        @(posedge clk); #1;
        ic.start = 1;
        @(posedge clk); #1 ic.start = 0;
        rcv = 0; sent = 0; fe_c = 0; bubbles = 0; tog = 0; seen_rdy = 0; found = 0;
        for (int n = 0; n < 200 && !found; n++) begin
            @(negedge clk);
            if (ic.data_in_vld) begin
                chk($sformatf("t6 beat%0d ls/le", rcv), {ic.line_start, ic.line_end},
                    {rcv % 4 == 0, rcv % 4 == 3});
                chk($sformatf("t3 beat%0d win_vld", rcv), ic.win_vld, (rcv / 4) >= 2);
                chk($sformatf("t6 beat%0d data", rcv), ic.pix_data_out, pat(1000 + rcv));
                rcv++;
            end
            if (ic.frame_end) begin
                fe_c++;
                chk("t6 frame_end on last beat", {ic.data_in_vld, ic.line_end, 32'(rcv)},
                    {1'b1, 1'b1, 32'd20});
            end
            if (n > 2 && !ic.busy) found = 1;
            tog = ~tog;
            ic.s_pix_vld = tog; ic.s_pix_data = pat(1000 + sent);
            #1;
            if (seen_rdy && ic.decoder_en && !ic.s_pix_rdy) bubbles++;
            if (ic.s_pix_rdy) seen_rdy = 1;
            xfer = ic.s_pix_vld & ic.s_pix_rdy;
            if (xfer)
                chk($sformatf("t3 send%0d row/line/beat", sent),
                    {ic.row_sel, ic.line_cnt, ic.beat_cnt},
                    {2'((sent / 4) % 3), 12'(sent / 4), 12'(sent % 4)});
            @(posedge clk);
            if (xfer) sent++;
        end
        ic.s_pix_vld = 0;
        chk("t6 frame finished", found, 1);
        chk("t6 beats sent", sent, 20);
        chk("t6 beats received", rcv, 20);
        chk("t6 frame_end count", fe_c, 1);
        chk("t6 no inter-line bubble", bubbles, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/swin_line_ctrl.md
Name: swin_line_ctrl

Overview:
- Line/frame scheduler in front of the configuration decoder: accepts 16-pixel beats from the upstream pixel stream with a valid/ready handshake and forwards them as a registered beat stream with data_in_vld.
- Sequences each frame: primes the configuration-BRAM read pipeline, counts beats per line and lines per frame, and inserts an inter-line gap so the decoder can finish line-end split writes.
- Emits the line_start/line_end/frame_end markers, the rotating BRAM row-group select and the window-valid flag used by the sliding-window read side.

Parameters:
- LINE_BEATS, 120, beats (16 pixels each) per image line; minimum 2.
- FRAME_LINES, 1080, lines per frame; minimum 1.
- WIN_ROWS, 3, number of BRAM row groups; row_sel rotates modulo this value.
- PRIME_CYC, 2, decoder_en lead cycles before the first beat of a frame (config BRAM read latency).
- GAP_CYC, 2, idle cycles inserted after every line except the last.
- CNT_W, 12, width of the beat and line counters.

Ports:
- clk  in  1  Single clock domain; all logic rising-edge.
- rst  in  1  Asynchronous, active-high reset.
- start  in  1  Frame start pulse; honoured only in IDLE.
- busy  out  1  High in every state except IDLE.
- s_pix_data  in  128  Upstream pixel beat, pixel 0 in bits [7:0].
- s_pix_vld  in  1  Upstream beat valid.
- s_pix_rdy  out  1  Upstream ready.
- dec_stall  in  1  Downstream back-pressure; blocks acceptance.
- pix_data_out  out  128  Registered beat to the decoder.
- data_in_vld  out  1  pix_data_out valid.
- decoder_en  out  1  Decoder and config-BRAM read enable.
- line_start  out  1  Qualifies the first beat of a line (with data_in_vld).
- line_end  out  1  Qualifies the last beat of a line.
- frame_end  out  1  One-cycle pulse after the last beat of the frame.
- row_sel  out  2  Current BRAM row group, 0..WIN_ROWS-1.
- win_vld  out  1  High while the current line index is >= WIN_ROWS-1.
- line_cnt  out  CNT_W  Current line index.
- beat_cnt  out  CNT_W  Next beat index within the line.

Behaviour:
- Reset: state IDLE; all outputs 0, including pix_data_out, counters and row_sel.
- FSM states: IDLE, PRIME, RUN, GAP, DONE.
- IDLE: on start, go to PRIME and clear beat_cnt, line_cnt and row_sel. start in any other state is ignored.
- PRIME: decoder_en=1 for exactly PRIME_CYC cycles, then go to RUN.
- decoder_en is 1 in PRIME, RUN and GAP, and 0 in IDLE and DONE.
- s_pix_rdy = (state==RUN) & ~dec_stall, combinational. A transfer is s_pix_vld & s_pix_rdy.
- Transfer timing: on a transfer, pix_data_out <= s_pix_data and data_in_vld <= 1 on the next edge (latency 1). Otherwise data_in_vld <= 0 and pix_data_out holds its value.
- On each transfer, line_start <= (beat_cnt==0) and line_end <= (beat_cnt==LINE_BEATS-1). Both are registered alongside data_in_vld and are 0 when data_in_vld is 0.
- Transfer of a non-last beat: beat_cnt increments.
- Transfer of the last beat of a line: beat_cnt <= 0.
  - Not the last line: line_cnt increments, row_sel <= (row_sel==WIN_ROWS-1) ? 0 : row_sel+1, and go to GAP.
  - Last line: go to DONE.
- GAP: s_pix_rdy=0 for GAP_CYC cycles, then return to RUN. With GAP_CYC=0, go straight from the last beat to RUN with no bubble.
- DONE: frame_end=1 for one cycle, coinciding with the data_in_vld/line_end of the final beat; then go to IDLE. busy drops the following cycle.
- win_vld = (line_cnt >= WIN_ROWS-1), registered with the beat so it matches data_in_vld timing.
- dec_stall in RUN: no transfer occurs and the counters hold; there is no limit on stall duration.
- dec_stall in PRIME or GAP: no effect; their cycle counts still elapse.
- Counter arithmetic is unsigned CNT_W bits; LINE_BEATS and FRAME_LINES must each be <= 2^CNT_W.
- Reset mid-frame: immediate return to IDLE with all outputs 0. A partially forwarded line is discarded, with no frame_end and no line_end.
- s_pix_data is sampled only when a transfer occurs.

Test Plan:
1. LINE_BEATS=4, FRAME_LINES=2, PRIME_CYC=2, GAP_CYC=2; start pulse with s_pix_vld held high -> decoder_en rises the cycle after start; the first transfer occurs 2 cycles later; data_in_vld shows the pattern 1111,0,0,1111 (the two-cycle gap); line_end asserts on beats 3 and 7; frame_end coincides with beat 7; busy=0 one cycle later.
2. Stall: dec_stall=1 for 5 cycles mid-line at beat_cnt=2 -> s_pix_rdy=0, beat_cnt stays 2, data_in_vld=0 for those cycles; resumes with beat 2 carrying the correct data.
3. Row rotation: FRAME_LINES=5, WIN_ROWS=3 -> row_sel sequence per line is 0,1,2,0,1; win_vld=0 on lines 0-1 and 1 on lines 2-4.
4. start asserted during RUN -> ignored; beat and line counts unchanged; exactly one frame_end for the frame.
5. rst asserted at line 1, beat 2 -> all outputs 0 asynchronously, state IDLE; a new start runs a full clean frame beginning with line_start on beat 0.
6. Upstream bubbles: s_pix_vld toggles 1010... with GAP_CYC=0 -> only valid beats are counted; line_start/line_end fall on beats 0 and LINE_BEATS-1 with no bubble inserted between lines.
